// File: rtl/elastic_config_sequencer_if.sv
// Config-entry stream between the host/loader and the sequencer.
// A transfer happens on a clock edge where cfg_valid is high and cfg_stop is low.
//   master : the config source (drives the entry, receives cfg_stop)
//   slave  : the sequencer     (receives the entry, drives cfg_stop)
interface elastic_config_sequencer_if #(
    parameter int PE_ID_WIDTH             = 4,
    parameter int CONTEXT_SIZE_BIT_LENGTH = 3,
    parameter int CONFIG_PAYLOAD_WIDTH    = 64
);
    logic                               cfg_valid;
    logic                               cfg_stop;
    logic [PE_ID_WIDTH-1:0]             cfg_pe_id;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] cfg_context_index;
    logic [CONFIG_PAYLOAD_WIDTH-1:0]    cfg_payload;

    modport master (
        output cfg_valid, cfg_pe_id, cfg_context_index, cfg_payload,
        input  cfg_stop
    );

    modport slave (
        input  cfg_valid, cfg_pe_id, cfg_context_index, cfg_payload,
        output cfg_stop
    );
endinterface

// File: rtl/elastic_config_sequencer.sv
// Top-level controller for the elastic CGRA array: loads config entries from a
// valid/stop stream into the addressed PE, pulses start_exec to all PEs, runs
// the array for a programmed number of cycles and reports done/error.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   cmd_*                   host command: start/abort, entry count, max context id, run length
//   cfg_if (slave)          config-entry stream (valid/stop, pe id, context slot, payload)
//   pe_write_config/...     registered one-hot write strobe with broadcast slot and payload
//   start_exec              one-cycle start pulse to every PE
//   mapping_context_max_id  max context id latched at command accept
//   busy/done/error         status; error is sticky until the next accepted start
//   exec_cycle_count        cycles spent in RUN
module elastic_config_sequencer #(
    parameter int PE_NUM                  = 16,
    parameter int PE_ID_WIDTH             = 4,
    parameter int CONTEXT_SIZE_BIT_LENGTH = 3,
    parameter int CONFIG_PAYLOAD_WIDTH    = 64,
    parameter int EXEC_CNT_WIDTH          = 32
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               cmd_start,
    input  logic                               cmd_abort,
    input  logic [15:0]                        cmd_entry_count,
    input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] cmd_context_max_id,
    input  logic [EXEC_CNT_WIDTH-1:0]          cmd_exec_cycles,
    elastic_config_sequencer_if.slave          cfg_if,
    output logic [PE_NUM-1:0]                  pe_write_config,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] pe_config_index,
    output logic [CONFIG_PAYLOAD_WIDTH-1:0]    pe_config_payload,
    output logic                               start_exec,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id,
    output logic                               busy,
    output logic                               done,
    output logic                               error,
    output logic [EXEC_CNT_WIDTH-1:0]          exec_cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_START, S_RUN, S_DONE
    } state_e;

    state_e                             state_q, state_d;
    logic [15:0]                        remaining_q, remaining_d;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] max_id_q, max_id_d;
    logic [EXEC_CNT_WIDTH-1:0]          exec_target_q, exec_target_d;
    logic [EXEC_CNT_WIDTH-1:0]          exec_cnt_q, exec_cnt_d;
    logic                               error_q, error_d;
    logic [PE_NUM-1:0]                  wr_strobe_q, wr_strobe_d;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] wr_index_q, wr_index_d;
    logic [CONFIG_PAYLOAD_WIDTH-1:0]    wr_payload_q, wr_payload_d;

    logic [PE_NUM-1:0]         pe_onehot;
    logic                      entry_bad;
    logic                      transfer;
    logic [EXEC_CNT_WIDTH-1:0] exec_cnt_inc;

    function automatic logic [EXEC_CNT_WIDTH-1:0] sat_inc(input logic [EXEC_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + EXEC_CNT_WIDTH'(1);
    endfunction

    assign cfg_if.cfg_stop = (state_q != S_LOAD);
    assign transfer        = cfg_if.cfg_valid && !cfg_if.cfg_stop;

    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        max_id_d      = max_id_q;
        exec_target_d = exec_target_q;
        exec_cnt_d    = exec_cnt_q;
        error_d       = error_q;
        wr_strobe_d   = '0;
        wr_index_d    = wr_index_q;
        wr_payload_d  = wr_payload_q;
        exec_cnt_inc  = sat_inc(exec_cnt_q);

        // Shifting past the top bit yields zero, so an all-zero one-hot marks
        // a PE id outside the array without a separate range compare.
        pe_onehot = PE_NUM'(1) << cfg_if.cfg_pe_id;
        entry_bad = (pe_onehot == '0) || (cfg_if.cfg_context_index > max_id_q);

        case (state_q)
            S_IDLE: begin
                if (cmd_start && !cmd_abort) begin
                    remaining_d   = cmd_entry_count;
                    max_id_d      = cmd_context_max_id;
                    exec_target_d = cmd_exec_cycles;
                    error_d       = 1'b0;
                    exec_cnt_d    = '0;
                    state_d       = (cmd_entry_count != 16'd0) ? S_LOAD : S_SETTLE;
                end
            end
            S_LOAD: begin
                if (transfer) begin
                    remaining_d = remaining_q - 16'd1;
                    if (entry_bad) begin
                        error_d = 1'b1;
                    end else begin
                        wr_strobe_d  = pe_onehot;
                        wr_index_d   = cfg_if.cfg_context_index;
                        wr_payload_d = cfg_if.cfg_payload;
                    end
                    if (remaining_q == 16'd1) begin
                        state_d = S_SETTLE;
                    end
                end
            end
            S_SETTLE: state_d = S_START;
            S_START: begin
                exec_cnt_d = '0;
                state_d    = (exec_target_q == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                exec_cnt_d = exec_cnt_inc;
                if (exec_cnt_inc == exec_target_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort freezes the counters; the write path above is left alone so a
        // strobe already registered (or accepted this cycle) still goes out.
        if (cmd_abort && state_q != S_IDLE) begin
            state_d     = S_IDLE;
            exec_cnt_d  = exec_cnt_q;
            remaining_d = remaining_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            remaining_q   <= '0;
            max_id_q      <= '0;
            exec_target_q <= '0;
            exec_cnt_q    <= '0;
            error_q       <= 1'b0;
            wr_strobe_q   <= '0;
            wr_index_q    <= '0;
            wr_payload_q  <= '0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            max_id_q      <= max_id_d;
            exec_target_q <= exec_target_d;
            exec_cnt_q    <= exec_cnt_d;
            error_q       <= error_d;
            wr_strobe_q   <= wr_strobe_d;
            wr_index_q    <= wr_index_d;
            wr_payload_q  <= wr_payload_d;
        end
    end

    assign pe_write_config        = wr_strobe_q;
    assign pe_config_index        = wr_index_q;
    assign pe_config_payload      = wr_payload_q;
    assign start_exec             = (state_q == S_START);
    assign done                   = (state_q == S_DONE);
    assign busy                   = (state_q != S_IDLE);
    assign error                  = error_q;
    assign mapping_context_max_id = max_id_q;
    assign exec_cycle_count       = exec_cnt_q;

endmodule

// File: tb/tb_elastic_config_sequencer.sv
// Directed bench for elastic_config_sequencer. PE_ID_WIDTH is widened to 5 so
// that a PE id of 16 (one past the array) can be presented.
module tb_elastic_config_sequencer;

    localparam int PE_NUM = 16;
    localparam int PIDW   = 5;
    localparam int CTXW   = 3;
    localparam int PLW    = 64;
    localparam int ECW    = 32;

    logic            clk;
    logic            reset_n;
    logic            cmd_start;
    logic            cmd_abort;
    logic [15:0]     cmd_entry_count;
    logic [CTXW-1:0] cmd_context_max_id;
    logic [ECW-1:0]  cmd_exec_cycles;
    logic [PE_NUM-1:0] pe_write_config;
    logic [CTXW-1:0] pe_config_index;
    logic [PLW-1:0]  pe_config_payload;
    logic            start_exec;
    logic [CTXW-1:0] mapping_context_max_id;
    logic            busy;
    logic            done;
    logic            error;
    logic [ECW-1:0]  exec_cycle_count;

    elastic_config_sequencer_if #(
        .PE_ID_WIDTH(PIDW), .CONTEXT_SIZE_BIT_LENGTH(CTXW), .CONFIG_PAYLOAD_WIDTH(PLW)
    ) cfg_if ();

    elastic_config_sequencer #(
        .PE_NUM(PE_NUM), .PE_ID_WIDTH(PIDW), .CONTEXT_SIZE_BIT_LENGTH(CTXW),
        .CONFIG_PAYLOAD_WIDTH(PLW), .EXEC_CNT_WIDTH(ECW)
    ) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .cmd_start              (cmd_start),
        .cmd_abort              (cmd_abort),
        .cmd_entry_count        (cmd_entry_count),
        .cmd_context_max_id     (cmd_context_max_id),
        .cmd_exec_cycles        (cmd_exec_cycles),
        .cfg_if                 (cfg_if),
        .pe_write_config        (pe_write_config),
        .pe_config_index        (pe_config_index),
        .pe_config_payload      (pe_config_payload),
        .start_exec             (start_exec),
        .mapping_context_max_id (mapping_context_max_id),
        .busy                   (busy),
        .done                   (done),
        .error                  (error),
        .exec_cycle_count       (exec_cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [PE_NUM-1:0] strobe;
        logic [CTXW-1:0]   idx;
        logic [PLW-1:0]    pl;
    } wr_t;

    wr_t sb[$];
    wr_t mon_e;
    int  tests = 0;
    int  fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every strobe the DUT emits must match the oldest expected write.
    always @(negedge clk) begin
        if (reset_n && pe_write_config !== '0) begin
            if (sb.size() == 0) begin
                check("extra_strobe", 64'(pe_write_config), 64'(0));
            end else begin
                mon_e = sb.pop_front();
                check("sb_strobe",  64'(pe_write_config),   64'(mon_e.strobe));
                check("sb_index",   64'(pe_config_index),   64'(mon_e.idx));
                check("sb_payload", 64'(pe_config_payload), 64'(mon_e.pl));
            end
        end
    end

    task automatic cmd(input logic [15:0] cnt, input logic [CTXW-1:0] mid, input logic [ECW-1:0] ex);
        cmd_entry_count    = cnt;
        cmd_context_max_id = mid;
        cmd_exec_cycles    = ex;
        cmd_start          = 1'b1;
        step();
        cmd_start = 1'b0;
        check("cmd_busy",    64'(busy), 64'(1));
        check("cmd_map_id",  64'(mapping_context_max_id), 64'(mid));
        check("cmd_err_clr", 64'(error), 64'(0));
        check("cmd_cnt_clr", 64'(exec_cycle_count), 64'(0));
    endtask

    task automatic send(input logic [PIDW-1:0] pe, input logic [CTXW-1:0] ctx,
                        input logic [PLW-1:0] pl, input bit good, input bit gap);
        logic [PE_NUM-1:0] exp_strobe;
        wr_t e;
        int w;
        exp_strobe = good ? (PE_NUM'(1) << pe) : '0;
        cfg_if.cfg_valid         = 1'b1;
        cfg_if.cfg_pe_id         = pe;
        cfg_if.cfg_context_index = ctx;
        cfg_if.cfg_payload       = pl;
        w = 0;
        while (cfg_if.cfg_stop && w < 20) begin
            step();
            w++;
        end
        check("cfg_ready", 64'(cfg_if.cfg_stop), 64'(0));
        if (good) begin
            e.strobe = exp_strobe;
            e.idx    = ctx;
            e.pl     = pl;
            sb.push_back(e);
        end
        step();
        cfg_if.cfg_valid = 1'b0;
        check("strobe_next_cycle", 64'(pe_write_config), 64'(exp_strobe));
        if (gap) begin
            step();
            check("gap_no_strobe", 64'(pe_write_config), 64'(0));
        end
    endtask

    // Entered in the SETTLE cycle (one cycle after the last transfer).
    task automatic run_tail(input int e, input logic [CTXW-1:0] mid, input bit exp_err);
        int k;
        check("settle_busy",  64'(busy), 64'(1));
        check("settle_start", 64'(start_exec), 64'(0));
        step();
        check("start_exec", 64'(start_exec), 64'(1));
        check("start_done", 64'(done), 64'(0));
        k = 0;
        do begin
            step();
            k++;
        end while (!done && k < e + 20);
        check("done_latency", 64'(k), 64'(e + 1));
        check("done_exec_count", 64'(exec_cycle_count), 64'(e));
        check("run_map_id", 64'(mapping_context_max_id), 64'(mid));
        check("done_error", 64'(error), 64'(exp_err));
        step();
        check("done_one_cycle", 64'(done), 64'(0));
        check("idle_busy", 64'(busy), 64'(0));
        check("count_held", 64'(exec_cycle_count), 64'(e));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n            = 1'b0;
        cmd_start          = 1'b0;
        cmd_abort          = 1'b0;
        cmd_entry_count    = '0;
        cmd_context_max_id = '0;
        cmd_exec_cycles    = '0;
        cfg_if.cfg_valid         = 1'b0;
        cfg_if.cfg_pe_id         = '0;
        cfg_if.cfg_context_index = '0;
        cfg_if.cfg_payload       = '0;

        #3;
        check("rst_stop",   64'(cfg_if.cfg_stop), 64'(1));
        check("rst_strobe", 64'(pe_write_config), 64'(0));
        check("rst_busy",   64'(busy), 64'(0));
        check("rst_error",  64'(error), 64'(0));
        check("rst_count",  64'(exec_cycle_count), 64'(0));
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        step();

        // Continuous load of three entries, 4 run cycles.
        cmd(16'd3, 3'd2, 32'd4);
        send(5'd0,  3'd0, 64'h1111_0000_0000_0001, 1'b1, 1'b0);
        send(5'd5,  3'd1, 64'h2222_0000_0000_0020, 1'b1, 1'b0);
        send(5'd15, 3'd2, 64'h3333_0000_0000_8000, 1'b1, 1'b0);
        run_tail(4, 3'd2, 1'b0);

        // Same load with a one-cycle gap between entries.
        cmd(16'd3, 3'd2, 32'd4);
        send(5'd0,  3'd0, 64'hA5A5_0000_0000_0001, 1'b1, 1'b1);
        send(5'd5,  3'd1, 64'hA5A5_0000_0000_0020, 1'b1, 1'b1);
        send(5'd15, 3'd2, 64'hA5A5_0000_0000_8000, 1'b1, 1'b0);
        run_tail(4, 3'd2, 1'b0);

        // Bad PE id, then bad context index.
        cmd(16'd2, 3'd2, 32'd3);
        send(5'd16, 3'd0, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0);
        check("err_after_bad_pe", 64'(error), 64'(1));
        send(5'd3,  3'd3, 64'hDEAD_BEEF_0000_0002, 1'b0, 1'b0);
        run_tail(3, 3'd2, 1'b1);

        // Zero entries, zero run cycles; cmd also shows error cleared.
        cmd(16'd0, 3'd0, 32'd0);
        run_tail(0, 3'd0, 1'b0);

        // Abort in RUN at count 2 of 10.
        cmd(16'd0, 3'd3, 32'd10);
        step();
        check("abort_start", 64'(start_exec), 64'(1));
        repeat (3) step();
        check("abort_pre_count", 64'(exec_cycle_count), 64'(2));
        cmd_abort = 1'b1;
        step();
        cmd_abort = 1'b0;
        check("abort_busy",  64'(busy), 64'(0));
        check("abort_done",  64'(done), 64'(0));
        check("abort_count", 64'(exec_cycle_count), 64'(2));
        repeat (3) begin
            step();
            check("abort_no_done", 64'(done), 64'(0));
        end
        check("abort_count_held", 64'(exec_cycle_count), 64'(2));

        // Start and abort together in IDLE: abort wins.
        cmd_start = 1'b1;
        cmd_abort = 1'b1;
        step();
        cmd_start = 1'b0;
        cmd_abort = 1'b0;
        check("start_abort_idle", 64'(busy), 64'(0));

        // Reset in the middle of LOAD.
        cmd(16'd3, 3'd2, 32'd4);
        send(5'd7, 3'd1, 64'h0BAD_F00D_0000_0080, 1'b1, 1'b0);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("mrst_stop",    64'(cfg_if.cfg_stop), 64'(1));
        check("mrst_strobe",  64'(pe_write_config), 64'(0));
        check("mrst_index",   64'(pe_config_index), 64'(0));
        check("mrst_payload", 64'(pe_config_payload), 64'(0));
        check("mrst_start",   64'(start_exec), 64'(0));
        check("mrst_done",    64'(done), 64'(0));
        check("mrst_busy",    64'(busy), 64'(0));
        check("mrst_error",   64'(error), 64'(0));
        check("mrst_map_id",  64'(mapping_context_max_id), 64'(0));
        check("mrst_count",   64'(exec_cycle_count), 64'(0));
        #3 reset_n = 1'b1;
        repeat (2) step();
        check("post_rst_busy", 64'(busy), 64'(0));
        check("sb_drained", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/elastic_config_sequencer.md
# elastic_config_sequencer

Top-level controller for the elastic CGRA array. It accepts config entries over a SELF (valid/stop) stream and distributes each one to the addressed PE's config-write port. It then pulses `start_exec` to every PE with a shared `mapping_context_max_id`, runs the array for a programmed number of cycles, and reports done or error to the host. It sits between the host/loader and the PE grid; it owns every PE's `write_config_data`, `config_index` and `start_exec`.

## Interface
Parameters:
- PE_NUM, 16, number of PEs driven
- PE_ID_WIDTH, 4, width of the PE select field
- CONTEXT_SIZE_BIT_LENGTH, 3, width of the context index
- CONFIG_PAYLOAD_WIDTH, 64, opaque packed PE config word (input indices, output mask, op, const)
- EXEC_CNT_WIDTH, 32, width of the cycle counters

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_start  in  1  begin load+run; sampled only in IDLE
- cmd_abort  in  1  return to IDLE from any non-IDLE state
- cmd_entry_count  in  16  number of config entries to load
- cmd_context_max_id  in  CONTEXT_SIZE_BIT_LENGTH  last valid context id
- cmd_exec_cycles  in  EXEC_CNT_WIDTH  cycles to stay in RUN
- cfg_valid  in  1  config entry valid
- cfg_stop  out  1  back-pressure to config source
- cfg_pe_id  in  PE_ID_WIDTH  target PE
- cfg_context_index  in  CONTEXT_SIZE_BIT_LENGTH  target context slot
- cfg_payload  in  CONFIG_PAYLOAD_WIDTH  config word
- pe_write_config  out  PE_NUM  one-hot write strobe
- pe_config_index  out  CONTEXT_SIZE_BIT_LENGTH  broadcast context slot
- pe_config_payload  out  CONFIG_PAYLOAD_WIDTH  broadcast config word
- start_exec  out  1  one-cycle start pulse to all PEs
- mapping_context_max_id  out  CONTEXT_SIZE_BIT_LENGTH  latched max id
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- error  out  1  sticky bad-entry flag; cleared on accepted cmd_start
- exec_cycle_count  out  EXEC_CNT_WIDTH  cycles spent in RUN

## Operation
- States: IDLE, LOAD, SETTLE, START, RUN, DONE.
- IDLE:
  - cfg_stop=1.
  - On cmd_start: latch entry count, max id and exec cycles; clear error and exec_cycle_count.
  - Go to LOAD if count>0, else SETTLE.
- LOAD:
  - cfg_stop=0. A transfer is cfg_valid & !cfg_stop.
  - Each transfer decrements the remaining-entry count. The transfer that makes it 0 moves the FSM to SETTLE.
  - Bad entry: cfg_pe_id>=PE_NUM or cfg_context_index>max id. Set error; the entry is consumed with no write strobe.
- SETTLE: one cycle, cfg_stop=1; guarantees the last write lands before start.
- START: start_exec=1 for exactly one cycle; exec counter cleared. Go to DONE if exec cycles==0, else RUN.
- RUN: exec_cycle_count += 1 per cycle. Go to DONE on the cycle the incremented value equals latched exec cycles.
- DONE: done=1 for one cycle, then IDLE. exec_cycle_count holds its value until the next accepted cmd_start.
- cmd_abort:
  - Next state IDLE with no done pulse.
  - In-flight registered write strobe still completes.
  - error and exec_cycle_count are retained.
- Simultaneous cmd_start and cmd_abort in IDLE: abort wins, start ignored.
- cmd_start outside IDLE is ignored.
- Counters do not wrap: exec_cycle_count saturates at all-ones (reachable only if exec cycles is all-ones).

## Timing
- Reset:
  - state IDLE, cfg_stop=1.
  - pe_write_config=0, pe_config_index=0, pe_config_payload=0.
  - start_exec=0, done=0, busy=0, error=0.
  - mapping_context_max_id=0, exec_cycle_count=0.
- Reset mid-operation aborts immediately; all outputs return to reset values asynchronously.
- Write path is registered: a transfer in cycle n drives pe_write_config one-hot, index and payload in cycle n+1, for one cycle.
- Back-to-back transfers give back-to-back strobes; throughput is 1 entry/cycle.
- Last transfer in cycle n:
  - n+1 = SETTLE (last strobe visible)
  - n+2 = START (start_exec high)
  - n+3 = first RUN cycle
- With E = exec cycles > 0: done is high E+1 cycles after start_exec (cycle n+3+E). exec_cycle_count=E during that cycle.
- mapping_context_max_id updates the cycle after cmd_start is accepted and is stable through RUN.

## Test plan
- 3 entries (pe 0/ctx 0, pe 5/ctx 1, pe 15/ctx 2), max id 2, exec 4, continuous valid -> strobes 0x0001, 0x0020, 0x8000 on consecutive cycles; start_exec 2 cycles after the last transfer; done 5 cycles after start_exec; exec_cycle_count=4; error=0.
- Same load with cfg_valid gapped every other cycle -> identical strobe contents, each one cycle after its transfer; no extra strobes.
- Entry pe_id=16 (PE_NUM=16), then entry ctx=3 with max id 2 -> no strobes for either, error=1, sequence still completes with done; next cmd_start clears error.
- entry count 0, exec 0 -> SETTLE, START, DONE: start_exec and done on consecutive cycles.
- cmd_abort during RUN at count 2 of 10 -> IDLE next cycle, no done, busy=0, exec_cycle_count=2; reset_n low mid-LOAD -> all outputs at reset values immediately.
